pipe_wb_regfile: RTL and testbench
==================================

Name: pipe_wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register. Takes the registered write-back bundle (wwreg, wm2reg, wrn, wmo, walu), selects the write-back data and commits it to a 32x32 register file.
- Also serves the ID stage:
  - two read ports with write-through bypass;
  - EX/MEM forwarding selects and forwarded operands;
  - load-use stall detection;
  - write-back retire counter for debug.

Parameters:
- NREG, 32, number of architectural registers (address width fixed at 5).
- DW, 32, data width.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- wwreg  in  1  write-back enable from MEM/WB.
- wm2reg  in  1  1 = write wmo, 0 = write walu.
- wrn  in  5  write-back destination register.
- wmo  in  DW  memory data from MEM/WB.
- walu  in  DW  ALU result from MEM/WB.
- rs  in  5  ID read address A.
- rt  in  5  ID read address B.
- users  in  1  ID instruction reads rs.
- usert  in  1  ID instruction reads rt.
- ewreg, em2reg  in  1 each  EX-stage write and load flags.
- ern  in  5  EX-stage destination.
- ealu  in  DW  EX-stage ALU result.
- mwreg, mm2reg  in  1 each  MEM-stage write and load flags.
- mrn  in  5  MEM-stage destination.
- malu  in  DW  MEM-stage ALU result.
- mmo  in  DW  MEM-stage load data.
- wdi  out  DW  selected write-back data.
- qa, qb  out  DW  register-file read data, with bypass.
- fwda, fwdb  out  2  forwarding selects.
- da, db  out  DW  forwarded operands.
- stall  out  1  load-use hazard; ID must hold.
- wbcount  out  32  retired write-back counter.

Behaviour:
- Reset (resetn=0, asynchronous): registers 1..31 cleared to 0; wbcount=0. All other outputs are combinational and follow from the cleared state.
- Write-back data: wdi = wm2reg ? wmo : walu, combinational.
- Commit: at posedge clock, if wwreg=1 and wrn!=0, reg[wrn] <= wdi.
  - wrn=0 never writes.
  - Register 0 always reads 0.
- Read ports are combinational: qa = (rs==0) ? 0 : (wwreg && wrn==rs) ? wdi : reg[rs]. qb is the same with rt.
  - The bypass makes a same-cycle write visible in the same cycle.
- Forwarding select for rs (fwdb identical with rt), first match wins:
  1. ewreg && !em2reg && ern!=0 && ern==rs -> 01, ealu.
  2. mwreg && mrn!=0 && mrn==rs -> 10 (malu) when mm2reg=0, 11 (mmo) when mm2reg=1.
  3. Otherwise 00, qa.
- EX takes priority over MEM when both match (newest value).
- da/db: 4:1 mux of {qa, ealu, malu, mmo} indexed by fwda/fwdb.
- stall = ewreg && em2reg && ern!=0 && ((users && ern==rs) || (usert && ern==rt)). Combinational, no internal state.
- While stall=1, forwarding selects are still driven but are don't-care for the consumer.
- wbcount increments by 1 at posedge when wwreg=1 and wrn!=0. It wraps 0xFFFFFFFF -> 0.
- Reset asserted mid-operation: clears state immediately; the write pending that cycle is lost.

Test Plan:
- Reset: pulse resetn low, read rs=1..31 -> qa=0; wbcount=0. Drive rs=0 with wwreg=1, wrn=0, walu=0xDEAD, clock -> qa=0; wbcount stays 0.
- Write then read: wwreg=1, wm2reg=0, wrn=5, walu=0x1234, clock. Then wwreg=0, rs=5 -> qa=0x1234. Repeat with wm2reg=1, wmo=0xCAFE -> reg5=0xCAFE; wbcount=2.
- Same-cycle bypass: reg7=0x11; wwreg=1, wrn=7, walu=0x22, rt=7 before the edge -> qb=0x22 combinationally; after the edge qb=0x22.
- Forward priority: ewreg=1, em2reg=0, ern=3, ealu=0xA, and mwreg=1, mrn=3, malu=0xB, rs=3 -> fwda=01, da=0xA. Drop ewreg -> fwda=10, da=0xB. Set mm2reg=1, mmo=0xC -> fwda=11, da=0xC.
- Load-use: ewreg=1, em2reg=1, ern=9, rt=9, usert=1 -> stall=1. With usert=0 -> stall=0. With ern=0 -> stall=0.
- Counter wrap: force 0xFFFFFFFF via 2^32 writes or backdoor, one valid write -> wbcount=0.

Source files
------------

// File: rtl/pipe_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : pipe_wb_regfile
// Brief    : MEM/WB write-back commit into a 32x32 register file, with
//            bypassed ID read ports, EX/MEM forwarding, load-use stall
//            detection and a retired write-back counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_wb_regfile #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          wwreg,
  input  logic          wm2reg,
  input  logic [4:0]    wrn,
  input  logic [DW-1:0] wmo,
  input  logic [DW-1:0] walu,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic          users,
  input  logic          usert,
  input  logic          ewreg,
  input  logic          em2reg,
  input  logic [4:0]    ern,
  input  logic [DW-1:0] ealu,
  input  logic          mwreg,
  input  logic          mm2reg,
  input  logic [4:0]    mrn,
  input  logic [DW-1:0] malu,
  input  logic [DW-1:0] mmo,
  output logic [DW-1:0] wdi,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb,
  output logic [1:0]    fwda,
  output logic [1:0]    fwdb,
  output logic [DW-1:0] da,
  output logic [DW-1:0] db,
  output logic          stall,
  output logic [31:0]   wbcount
);

  localparam logic [1:0] C_FWD_REG  = 2'b00;
  localparam logic [1:0] C_FWD_EALU = 2'b01;
  localparam logic [1:0] C_FWD_MALU = 2'b10;
  localparam logic [1:0] C_FWD_MMO  = 2'b11;

  logic [DW-1:0] r_regs [NREG];
  logic [31:0]   r_wbcount;
  logic          w_we;
  logic [DW-1:0] w_wdi;

  assign w_wdi = wm2reg ? wmo : walu;
  assign w_we  = wwreg && (wrn != 5'd0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_wbcount <= '0;
    end else if (w_we) begin
      r_regs[wrn] <= w_wdi;
      r_wbcount   <= r_wbcount + 32'd1;
    end
  end

  // Same-cycle write-back is visible to ID reads through the bypass.
  function automatic logic [DW-1:0] read_port(input logic [4:0] addr);
    if (addr == 5'd0)                read_port = '0;
    else if (wwreg && (wrn == addr)) read_port = w_wdi;
    else                             read_port = r_regs[addr];
  endfunction

  // EX is checked first so the youngest producer wins; an EX load cannot
  // forward yet and is covered by the stall instead.
  function automatic logic [1:0] fwd_sel(input logic [4:0] addr);
    if (ewreg && !em2reg && (ern != 5'd0) && (ern == addr))
      fwd_sel = C_FWD_EALU;
    else if (mwreg && (mrn != 5'd0) && (mrn == addr))
      fwd_sel = mm2reg ? C_FWD_MMO : C_FWD_MALU;
    else
      fwd_sel = C_FWD_REG;
  endfunction

  function automatic logic [DW-1:0] fwd_mux(input logic [1:0] sel,
                                            input logic [DW-1:0] q);
    case (sel)
      C_FWD_EALU: fwd_mux = ealu;
      C_FWD_MALU: fwd_mux = malu;
      C_FWD_MMO:  fwd_mux = mmo;
      default:    fwd_mux = q;
    endcase
  endfunction

  always_comb begin
    qa    = read_port(rs);
    qb    = read_port(rt);
    fwda  = fwd_sel(rs);
    fwdb  = fwd_sel(rt);
    da    = fwd_mux(fwda, qa);
    db    = fwd_mux(fwdb, qb);
    stall = ewreg && em2reg && (ern != 5'd0) &&
            ((users && (ern == rs)) || (usert && (ern == rt)));
  end

  assign wdi     = w_wdi;
  assign wbcount = r_wbcount;

endmodule
`default_nettype wire

// File: tb/tb_pipe_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_wb_regfile
// Brief    : Directed plus randomized bench for pipe_wb_regfile against an
//            array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_wb_regfile;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wwreg, wm2reg, users, usert, ewreg, em2reg, mwreg, mm2reg;
  logic [4:0]  wrn, rs, rt, ern, mrn;
  logic [31:0] wmo, walu, ealu, malu, mmo;
  logic [31:0] wdi, qa, qb, da, db, wbcount;
  logic [1:0]  fwda, fwdb;
  logic        stall;

  logic [31:0] m_regs [32];
  logic [31:0] m_count;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  pipe_wb_regfile #(.NREG(32), .DW(32)) dut (
    .clock(clk), .resetn(resetn),
    .wwreg(wwreg), .wm2reg(wm2reg), .wrn(wrn), .wmo(wmo), .walu(walu),
    .rs(rs), .rt(rt), .users(users), .usert(usert),
    .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .ealu(ealu),
    .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .malu(malu), .mmo(mmo),
    .wdi(wdi), .qa(qa), .qb(qb), .fwda(fwda), .fwdb(fwdb),
    .da(da), .db(db), .stall(stall), .wbcount(wbcount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_wdi();
    return wm2reg ? wmo : walu;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (wwreg && wrn == a) return m_wdi();
    return m_regs[a];
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] a);
    if (ewreg && !em2reg && ern != 0 && ern == a) return 2'd1;
    if (mwreg && mrn != 0 && mrn == a) return mm2reg ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] m_operand(input logic [4:0] a);
    logic [31:0] vals [4];
    vals[0] = m_read(a); vals[1] = ealu; vals[2] = malu; vals[3] = mmo;
    return vals[m_fwd(a)];
  endfunction

  function automatic logic m_stall();
    return ewreg && em2reg && ern != 0 &&
           ((users && ern == rs) || (usert && ern == rt));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_count = 32'd0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".wdi"},   wdi,            m_wdi());
    check({tag, ".qa"},    qa,             m_read(rs));
    check({tag, ".qb"},    qb,             m_read(rt));
    check({tag, ".fwda"},  {30'd0, fwda},  {30'd0, m_fwd(rs)});
    check({tag, ".fwdb"},  {30'd0, fwdb},  {30'd0, m_fwd(rt)});
    check({tag, ".da"},    da,             m_operand(rs));
    check({tag, ".db"},    db,             m_operand(rt));
    check({tag, ".stall"}, {31'd0, stall}, {31'd0, m_stall()});
    check({tag, ".cnt"},   wbcount,        m_count);
  endtask

  // Model commit uses the pre-edge inputs; DUT is sampled 1 time unit later.
  task automatic tick();
    if (wwreg && wrn != 0) begin
      m_regs[wrn] = m_wdi();
      m_count     = m_count + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {wwreg, wm2reg, users, usert, ewreg, em2reg, mwreg, mm2reg} = '0;
    {wrn, rs, rt, ern, mrn} = '0;
    {wmo, walu, ealu, malu, mmo} = '0;
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Reset state
    for (int i = 1; i < 32; i++) begin
      rs = 5'(i); #1;
      check("rst_qa", qa, 32'd0);
    end
    check("rst_cnt", wbcount, 32'd0);

    // r0 write ignored
    rs = 0; wwreg = 1; wrn = 0; walu = 32'hDEAD; #1;
    check("r0_qa_pre", qa, 32'd0);
    tick();
    check("r0_qa", qa, 32'd0);
    check("r0_cnt", wbcount, 32'd0);

    // Write then read, ALU then memory source
    wwreg = 1; wm2reg = 0; wrn = 5; walu = 32'h1234; tick();
    wwreg = 0; rs = 5; #1;
    check("wr_alu", qa, 32'h1234);
    wwreg = 1; wm2reg = 1; wrn = 5; wmo = 32'hCAFE; tick();
    wwreg = 0; #1;
    check("wr_mem", qa, 32'hCAFE);
    check("wr_cnt", wbcount, 32'd2);

    // Same-cycle bypass
    wwreg = 1; wm2reg = 0; wrn = 7; walu = 32'h11; tick();
    walu = 32'h22; rt = 7; #1;
    check("byp_pre", qb, 32'h22);
    tick();
    wwreg = 0; #1;
    check("byp_post", qb, 32'h22);

    // Forwarding priority
    idle();
    ewreg = 1; ern = 3; ealu = 32'hA; mwreg = 1; mrn = 3; malu = 32'hB; rs = 3; #1;
    check("fwd_ex_sel", {30'd0, fwda}, 32'd1);
    check("fwd_ex_da", da, 32'hA);
    ewreg = 0; #1;
    check("fwd_mem_sel", {30'd0, fwda}, 32'd2);
    check("fwd_mem_da", da, 32'hB);
    mm2reg = 1; mmo = 32'hC; #1;
    check("fwd_ld_sel", {30'd0, fwda}, 32'd3);
    check("fwd_ld_da", da, 32'hC);

    // Load-use stall
    idle();
    ewreg = 1; em2reg = 1; ern = 9; rt = 9; usert = 1; #1;
    check("lu_stall", {31'd0, stall}, 32'd1);
    usert = 0; #1;
    check("lu_nouse", {31'd0, stall}, 32'd0);
    usert = 1; ern = 0; rt = 0; #1;
    check("lu_r0", {31'd0, stall}, 32'd0);

    // Counter wrap
    idle();
    force dut.r_wbcount = 32'hFFFF_FFFF;
    #1 release dut.r_wbcount;
    m_count = 32'hFFFF_FFFF;
    check("wrap_pre", wbcount, 32'hFFFF_FFFF);
    wwreg = 1; wrn = 12; walu = 32'h55; tick();
    check("wrap", wbcount, 32'd0);

    // Randomized traffic against the model, with one asynchronous reset
    for (int c = 0; c < 600; c++) begin
      wwreg  = 1'($urandom);   wm2reg = 1'($urandom);
      users  = 1'($urandom);   usert  = 1'($urandom);
      ewreg  = 1'($urandom);   em2reg = 1'($urandom);
      mwreg  = 1'($urandom);   mm2reg = 1'($urandom);
      wrn = 5'($urandom_range(0, 7)); rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7)); ern = 5'($urandom_range(0, 7));
      mrn = 5'($urandom_range(0, 7));
      if (c % 3 == 0) begin
        wrn = 5'($urandom); rs = 5'($urandom); rt = 5'($urandom);
      end
      wmo = $urandom; walu = $urandom; ealu = $urandom; malu = $urandom; mmo = $urandom;
      #1;
      check_all("rnd");
      if (c == 300) begin
        resetn = 1'b0; #1;
        model_reset();
        check("mid_rst_cnt", wbcount, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1; #1;
        check_all("post_rst");
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'd1, 32'd0);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
